// File: rtl/cpu_exec_unit.sv
// Execution support for the RV32 single-cycle core:
// integer ALU with branch flags, machine CSR file, load extender.
module cpu_exec_unit #(
   parameter logic [31:0] HART_ID    = 32'd0,
   parameter logic [31:0] MISA_VALUE = 32'h4000_0100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] alu_src_a,
   input  logic [31:0] alu_src_b,
   input  logic [3:0]  alu_control,
   output logic [31:0] alu_result,
   output logic        alu_zero,
   output logic        alu_borrow,
   output logic        alu_lt,
   input  logic [11:0] csr_raddr,
   output logic [31:0] csr_rdata,
   input  logic [11:0] csr_waddr,
   input  logic [31:0] csr_wdata,
   input  logic        csr_wenable,
   input  logic [31:0] ext_data,
   input  logic [2:0]  ext_control,
   output logic [31:0] ext_data_out
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b0001;
   localparam logic [3:0] OP_SLT  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b1101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;
   localparam logic [3:0] OP_PA   = 4'b1001;
   localparam logic [3:0] OP_PB   = 4'b1010;
   localparam logic [3:0] OP_ANDN = 4'b1011;

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MISA     = 12'h301;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MTVAL    = 12'h343;
   localparam logic [11:0] A_MIP      = 12'h344;
   localparam logic [11:0] A_MHARTID  = 12'hF14;

   // ---------------- ALU ----------------
   logic [32:0] diff;
   logic [4:0]  shamt;

   // A - B as A + ~B + 1 so the carry-out gives the borrow
   assign diff  = {1'b0, alu_src_a} + {1'b0, ~alu_src_b} + 33'd1;
   assign shamt = alu_src_b[4:0];

   assign alu_borrow = ~diff[32];
   assign alu_lt = (alu_src_a[31] != alu_src_b[31]) ?
                   alu_src_a[31] : diff[31];

   always_comb begin
      alu_result = 32'd0;
      case (alu_control)
         OP_ADD:  alu_result = alu_src_a + alu_src_b;
         OP_SUB:  alu_result = diff[31:0];
         OP_SLL:  alu_result = alu_src_a << shamt;
         OP_SLT:  alu_result = {31'd0, alu_lt};
         OP_SLTU: alu_result = {31'd0, alu_borrow};
         OP_XOR:  alu_result = alu_src_a ^ alu_src_b;
         OP_SRL:  alu_result = alu_src_a >> shamt;
         OP_SRA:  alu_result = $signed(alu_src_a) >>> shamt;
         OP_OR:   alu_result = alu_src_a | alu_src_b;
         OP_AND:  alu_result = alu_src_a & alu_src_b;
         OP_PA:   alu_result = alu_src_a;
         OP_PB:   alu_result = alu_src_b;
         OP_ANDN: alu_result = alu_src_a & ~alu_src_b;
         default: alu_result = 32'd0;
      endcase
   end

   assign alu_zero = (alu_result == 32'd0);

   // ---------------- CSR file ----------------
   logic [31:0] mstatus;
   logic [31:0] mie;
   logic [31:0] mtvec;
   logic [31:0] mscratch;
   logic [31:0] mepc;
   logic [31:0] mcause;
   logic [31:0] mtval;
   logic [31:0] mip;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mstatus  <= 32'd0;
         mie      <= 32'd0;
         mtvec    <= 32'd0;
         mscratch <= 32'd0;
         mepc     <= 32'd0;
         mcause   <= 32'd0;
         mtval    <= 32'd0;
         mip      <= 32'd0;
      end else if (csr_wenable) begin
         // read-only and unmapped addresses fall through silently
         case (csr_waddr)
            A_MSTATUS:  mstatus  <= csr_wdata;
            A_MIE:      mie      <= csr_wdata;
            A_MTVEC:    mtvec    <= {csr_wdata[31:2], 2'b00};
            A_MSCRATCH: mscratch <= csr_wdata;
            A_MEPC:     mepc     <= {csr_wdata[31:2], 2'b00};
            A_MCAUSE:   mcause   <= csr_wdata;
            A_MTVAL:    mtval    <= csr_wdata;
            A_MIP:      mip      <= csr_wdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      csr_rdata = 32'd0;
      case (csr_raddr)
         A_MSTATUS:  csr_rdata = mstatus;
         A_MISA:     csr_rdata = MISA_VALUE;
         A_MIE:      csr_rdata = mie;
         A_MTVEC:    csr_rdata = mtvec;
         A_MSCRATCH: csr_rdata = mscratch;
         A_MEPC:     csr_rdata = mepc;
         A_MCAUSE:   csr_rdata = mcause;
         A_MTVAL:    csr_rdata = mtval;
         A_MIP:      csr_rdata = mip;
         A_MHARTID:  csr_rdata = HART_ID;
         default:    csr_rdata = 32'd0;
      endcase
   end

   // ---------------- load extender ----------------
   always_comb begin
      ext_data_out = ext_data;
      case (ext_control)
         3'b000: ext_data_out = {{24{ext_data[7]}}, ext_data[7:0]};
         3'b001: ext_data_out = {{16{ext_data[15]}}, ext_data[15:0]};
         3'b100: ext_data_out = {24'd0, ext_data[7:0]};
         3'b101: ext_data_out = {16'd0, ext_data[15:0]};
         default: ext_data_out = ext_data;
      endcase
   end

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Directed self-checking bench for cpu_exec_unit.
module tb_cpu_exec_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] alu_src_a;
   logic [31:0] alu_src_b;
   logic [3:0]  alu_control;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        alu_borrow;
   logic        alu_lt;
   logic [11:0] csr_raddr;
   logic [31:0] csr_rdata;
   logic [11:0] csr_waddr;
   logic [31:0] csr_wdata;
   logic        csr_wenable;
   logic [31:0] ext_data;
   logic [2:0]  ext_control;
   logic [31:0] ext_data_out;

   int checks = 0;
   int errors = 0;

   cpu_exec_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .alu_control  (alu_control),
      .alu_result   (alu_result),
      .alu_zero     (alu_zero),
      .alu_borrow   (alu_borrow),
      .alu_lt       (alu_lt),
      .csr_raddr    (csr_raddr),
      .csr_rdata    (csr_rdata),
      .csr_waddr    (csr_waddr),
      .csr_wdata    (csr_wdata),
      .csr_wenable  (csr_wenable),
      .ext_data     (ext_data),
      .ext_control  (ext_control),
      .ext_data_out (ext_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic alu(input logic [3:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b);
      alu_control = op;
      alu_src_a   = a;
      alu_src_b   = b;
      #1;
   endtask

   task automatic csr_rd(input logic [11:0] addr);
      csr_raddr = addr;
      #1;
   endtask

   task automatic csr_wr(input logic [11:0] addr,
                         input logic [31:0] data);
      @(negedge clk);
      csr_waddr   = addr;
      csr_wdata   = data;
      csr_wenable = 1'b1;
      @(posedge clk);
      #1;
      csr_wenable = 1'b0;
   endtask

   logic [11:0] rw_addrs [8] = '{12'h300, 12'h304, 12'h305, 12'h340,
                                 12'h341, 12'h342, 12'h343, 12'h344};
   logic [31:0] ext_exp  [8] = '{32'hFFFF_FF81, 32'hFFFF_8081,
                                 32'h0000_8081, 32'h0000_8081,
                                 32'h0000_0081, 32'h0000_8081,
                                 32'h0000_8081, 32'h0000_8081};

   initial begin
      rst_n = 1'b0;
      alu_src_a = '0;
      alu_src_b = '0;
      alu_control = '0;
      csr_raddr = '0;
      csr_waddr = '0;
      csr_wdata = '0;
      csr_wenable = 1'b0;
      ext_data = '0;
      ext_control = '0;
      #12;
      csr_rd(12'h340);
      check("rst_mscratch", csr_rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU arithmetic and flags
      alu(4'b0000, 32'hFFFF_FFFF, 32'h1);
      check("add_wrap", alu_result, 32'h0);
      check("add_zero", {31'd0, alu_zero}, 32'h1);
      alu(4'b1000, 32'd5, 32'd7);
      check("sub_neg", alu_result, 32'hFFFF_FFFE);
      check("sub_neg_borrow", {31'd0, alu_borrow}, 32'h1);
      check("sub_neg_lt", {31'd0, alu_lt}, 32'h1);
      alu(4'b1000, 32'h8000_0000, 32'h1);
      check("sub_ovf", alu_result, 32'h7FFF_FFFF);
      check("sub_ovf_lt", {31'd0, alu_lt}, 32'h1);
      check("sub_ovf_borrow", {31'd0, alu_borrow}, 32'h0);
      alu(4'b1000, 32'd3, 32'd3);
      check("eq_zero", {31'd0, alu_zero}, 32'h1);
      check("eq_lt", {31'd0, alu_lt}, 32'h0);
      check("eq_borrow", {31'd0, alu_borrow}, 32'h0);
      // flags independent of op
      alu(4'b0110, 32'd5, 32'd7);
      check("or_borrow", {31'd0, alu_borrow}, 32'h1);
      check("or_zero", {31'd0, alu_zero}, 32'h0);

      // shifts and compares
      alu(4'b1101, 32'h8000_0000, 32'h21);
      check("sra", alu_result, 32'hC000_0000);
      alu(4'b0101, 32'h8000_0000, 32'h21);
      check("srl", alu_result, 32'h4000_0000);
      alu(4'b0001, 32'h1, 32'd31);
      check("sll", alu_result, 32'h8000_0000);
      alu(4'b0010, 32'hFFFF_FFFF, 32'h1);
      check("slt", alu_result, 32'h1);
      alu(4'b0011, 32'hFFFF_FFFF, 32'h1);
      check("sltu", alu_result, 32'h0);
      alu(4'b0100, 32'hF0F0_1234, 32'h0FF0_FFFF);
      check("xor", alu_result, 32'hFF00_EDCB);
      alu(4'b0111, 32'hF0F0_1234, 32'h0FF0_FFFF);
      check("and", alu_result, 32'h00F0_1234);

      // pass and mask
      alu(4'b1010, 32'hAAAA_AAAA, 32'h1234);
      check("pass_b", alu_result, 32'h1234);
      alu(4'b1001, 32'hDEAD_BEEF, 32'h5);
      check("pass_a", alu_result, 32'hDEAD_BEEF);
      alu(4'b1011, 32'hFF, 32'h0F);
      check("and_not", alu_result, 32'hF0);
      alu(4'b1111, 32'h1234, 32'h5678);
      check("op_1111", alu_result, 32'h0);
      alu(4'b1100, 32'h1234, 32'h5678);
      check("op_1100", alu_result, 32'h0);

      // CSR read-during-write then next-cycle visibility
      @(negedge clk);
      csr_raddr   = 12'h340;
      csr_waddr   = 12'h340;
      csr_wdata   = 32'hCAFE_BABE;
      csr_wenable = 1'b1;
      #1;
      check("rdw_old", csr_rdata, 32'h0);
      @(posedge clk);
      #1;
      csr_wenable = 1'b0;
      check("rdw_new", csr_rdata, 32'hCAFE_BABE);

      csr_wr(12'h341, 32'h0000_1003);
      csr_rd(12'h341);
      check("mepc_align", csr_rdata, 32'h0000_1000);
      csr_wr(12'h305, 32'h8000_00FF);
      csr_rd(12'h305);
      check("mtvec_align", csr_rdata, 32'h8000_00FC);
      csr_wr(12'h342, 32'h8000_000B);
      csr_rd(12'h342);
      check("mcause", csr_rdata, 32'h8000_000B);
      csr_wr(12'h301, 32'h1234_5678);
      csr_rd(12'h301);
      check("misa_ro", csr_rdata, 32'h4000_0100);
      csr_wr(12'hF14, 32'h1);
      csr_rd(12'hF14);
      check("mhartid", csr_rdata, 32'h0);
      csr_wr(12'h7C0, 32'h5555_5555);
      csr_rd(12'h7C0);
      check("unmapped", csr_rdata, 32'h0);
      csr_rd(12'h340);
      check("mscratch_kept", csr_rdata, 32'hCAFE_BABE);

      // async reset between edges, write strobe held during reset
      csr_wr(12'h300, 32'h0000_1888);
      csr_wr(12'h343, 32'hFFFF_FFFF);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      foreach (rw_addrs[i]) begin
         csr_rd(rw_addrs[i]);
         check($sformatf("rst_%03h", rw_addrs[i]), csr_rdata, 32'h0);
      end
      csr_waddr   = 12'h340;
      csr_wdata   = 32'h1111_2222;
      csr_wenable = 1'b1;
      @(posedge clk);
      #1;
      csr_wenable = 1'b0;
      csr_rd(12'h340);
      check("rst_write_blocked", csr_rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      csr_rd(12'h301);
      check("misa_after_rst", csr_rdata, 32'h4000_0100);

      // load extender
      ext_data = 32'h0000_8081;
      for (int k = 0; k < 8; k++) begin
         ext_control = 3'(k);
         #1;
         check($sformatf("ext_%0d", k), ext_data_out, ext_exp[k]);
      end
      ext_data = 32'h1234_7F7F;
      ext_control = 3'b000;
      #1;
      check("lb_pos", ext_data_out, 32'h0000_007F);
      ext_control = 3'b001;
      #1;
      check("lh_pos", ext_data_out, 32'h0000_7F7F);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_exec_unit.md
Name: cpu_exec_unit

Overview:
Execution-support block for the RV32 single-cycle core. It bundles three independent sub-functions: a 32-bit integer ALU with branch flags, a machine-mode CSR file, and a load-data sign/zero extender. The ALU and extender are purely combinational. The CSR file has a combinational read port and a write port that updates on the clock edge.

Parameters:
HART_ID, 0, value returned by read-only CSR mhartid (0xF14).
MISA_VALUE, 32'h40000100, value returned by read-only CSR misa (0x301): RV32I.

Ports:
clk  in  1  clock; CSR writes update on rising edge
rst_n  in  1  asynchronous active-low reset (CSR state only)
alu_src_a  in  32  ALU operand A
alu_src_b  in  32  ALU operand B
alu_control  in  4  ALU operation select
alu_result  out  32  ALU result
alu_zero  out  1  alu_result == 0
alu_borrow  out  1  unsigned A < B
alu_lt  out  1  signed A < B
csr_raddr  in  12  CSR read address
csr_rdata  out  32  CSR read data (combinational)
csr_waddr  in  12  CSR write address
csr_wdata  in  32  CSR write data
csr_wenable  in  1  CSR write strobe
ext_data  in  32  raw load data (byte/half in low bits)
ext_control  in  3  load funct3
ext_data_out  out  32  extended load data

Behaviour:
ALU (combinational, no state). The encoding is {funct7[5], funct3}:
- 0000 ADD: A+B, mod 2^32.
- 1000 SUB: A−B.
- 0001 SLL: A << B[4:0].
- 0010 SLT: signed A<B ? 1 : 0.
- 0011 SLTU: unsigned A<B ? 1 : 0.
- 0100 XOR.
- 0101 SRL: logical A >> B[4:0].
- 1101 SRA: arithmetic A >>> B[4:0].
- 0110 OR.
- 0111 AND.
- 1001 PASS_A: A.
- 1010 PASS_B: B.
- 1011 AND_NOT: A & ~B (used by csrrc).
- 1100, 1110, 1111: result 0.

ALU flags:
- alu_zero is derived from alu_result.
- alu_borrow and alu_lt are always computed from the internal A−B, independent of alu_control.
- alu_borrow is the inverted carry-out of A + ~B + 1.
- alu_lt is (sign(A) != sign(B)) ? sign(A) : sign(A−B).

CSR file:
- Read is combinational from csr_raddr.
- Write occurs on rising clk when csr_wenable=1, to csr_waddr.
- Read-during-write to the same address returns the old value; the new value is visible the cycle after.
- Implemented R/W CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344.
- mtvec and mepc store wdata[31:2] with bits [1:0] forced to 0.
- Read-only CSRs: misa 0x301 = MISA_VALUE, mhartid 0xF14 = HART_ID. Writes to them are ignored.
- Any other address reads 0; writes to it are ignored and cause no error.
- rst_n low: all R/W CSRs are cleared to 0 immediately. Reset asserted mid-operation overrides any pending write.
- csr_rdata follows reset without waiting for a clock edge.

Data extender (combinational):
- 000 LB: sign-extend ext_data[7:0].
- 001 LH: sign-extend ext_data[15:0].
- 010 LW: ext_data unchanged.
- 100 LBU: zero-extend [7:0].
- 101 LHU: zero-extend [15:0].
- 011, 110, 111: pass ext_data unchanged.
- The extender does no lane shifting; the memory system presents the addressed byte/half in the low bits.

Test Plan:
1. ALU arithmetic and flags:
   - ADD 0xFFFFFFFF+1 → 0, zero=1.
   - SUB A=5, B=7 → 0xFFFFFFFE, borrow=1, lt=1.
   - SUB A=0x80000000, B=1 → 0x7FFFFFFF, lt=1, borrow=0.
   - A=B=3 → zero=1, lt=0, borrow=0.
2. ALU shifts and compares:
   - SRA 0x80000000 by B=0x21 (shamt 1) → 0xC0000000.
   - SRL same operands → 0x40000000.
   - SLL 1 by 31 → 0x80000000.
   - SLT(−1, 1) → 1.
   - SLTU(−1, 1) → 0.
3. ALU pass/mask ops:
   - PASS_B B=0x1234 → 0x1234.
   - PASS_A A=0xDEADBEEF → same.
   - AND_NOT A=0xFF, B=0x0F → 0xF0.
   - control 1111 → 0.
4. CSR write/read:
   - Write mscratch 0xCAFEBABE with wenable → rdata shows the old value 0 in the same cycle, 0xCAFEBABE the next cycle.
   - Write mepc 0x00001003 → reads 0x00001000.
   - Write misa → still reads 0x40000100.
   - Read 0x7C0 → 0.
5. CSR reset:
   - After writes, pulse rst_n low between clock edges → all R/W CSRs read 0 immediately.
   - A write strobe during reset has no effect.
6. Data extender, ext_data=0x0000_8081:
   - LB → 0xFFFFFF81.
   - LBU → 0x00000081.
   - LH → 0xFFFF8081.
   - LHU → 0x00008081.
   - LW → 0x00008081.
   - control 110 → 0x00008081.
